y86_mem_sys: RTL and testbench

Y86_MEM_SYS -- requirements
Module: y86_mem_sys

---
 rtl/y86_mem_sys.sv | 101 ++++++++++
 tb/tb_y86_mem_sys.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_sys.sv
// Y86 memory subsystem: byte-addressed RAM with little-endian word access,
// a TX byte FIFO, a free-running cycle counter and a sticky access-error flag.
module y86_mem_sys #(
  parameter int MEM_BYTES = 1024,
  parameter int TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_A,
  input  logic [31:0] bus_out,
  input  logic        bus_RE,
  input  logic        bus_WE,
  output logic [31:0] bus_in,
  input  logic        ld_en,
  input  logic [9:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] A_STATUS = 32'h400;
  localparam logic [31:0] A_TXDATA = 32'h404;
  localparam logic [31:0] A_CYCLES = 32'h408;

  logic                     sel_ram, sel_status, sel_txdata, sel_cycles, sel_unmapped;
  logic [7:0]               mem [MEM_BYTES];
  logic [TX_DEPTH-1:0][7:0] fifo_q;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic [31:0]              cyc_q, ram_word, status_word;
  logic [AW-1:0]            ram_base;
  logic                     full, empty, wr_tx, push, pop, drop, err_set, err_clr;

  assign sel_ram      = bus_A < 32'h400;
  assign sel_status   = bus_A == A_STATUS;
  assign sel_txdata   = bus_A == A_TXDATA;
  assign sel_cycles   = bus_A == A_CYCLES;
  assign sel_unmapped = !(sel_ram || sel_status || sel_txdata || sel_cycles);
  assign ram_base     = bus_A[AW-1:0];

  assign full     = count == CW'(TX_DEPTH);
  assign empty    = count == '0;
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr];
  assign pop      = !empty && tx_ready;
  assign wr_tx    = bus_WE && sel_txdata;
  // A pop on the same edge frees the slot, so a push to a full FIFO still lands.
  assign push     = wr_tx && (!full || pop);
  assign drop     = wr_tx && full && !pop;

  assign err_set = drop || (bus_WE && (sel_status || sel_unmapped)) || (bus_RE && bus_WE);
  assign err_clr = bus_WE && sel_status && bus_out[8];

  assign status_word = {23'd0, err, 1'b0, 5'(count), empty, full};

  // RAM has no reset; the bus write is issued last so it wins a same-byte clash.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr[AW-1:0]] <= ld_data;
    if (bus_WE && sel_ram)
      for (int i = 0; i < 4; i++) mem[ram_base + AW'(i)] <= bus_out[8*i +: 8];
  end

  always_comb begin
    ram_word = '0;
    for (int i = 0; i < 4; i++) ram_word[8*i +: 8] = mem[ram_base + AW'(i)];
  end

  always_comb begin
    bus_in = '0;
    if (bus_RE) begin
      if (sel_ram)         bus_in = ram_word;
      else if (sel_status) bus_in = status_word;
      else if (sel_cycles) bus_in = cyc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cyc_q  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= bus_out[7:0];
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      cyc_q <= (bus_WE && sel_cycles) ? '0 : cyc_q + 32'd1;
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_y86_mem_sys.sv
// Bench for y86_mem_sys: per-feature tasks, FIFO output checked against a byte scoreboard.
module tb_y86_mem_sys;
  logic        clk, rst;
  logic [31:0] bus_A, bus_out, bus_in;
  logic        bus_RE, bus_WE, ld_en, tx_valid, tx_ready, err;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data, tx_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  y86_mem_sys #(.MEM_BYTES(1024), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out), .bus_RE(bus_RE),
    .bus_WE(bus_WE), .bus_in(bus_in), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers are entered at a falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_A = a; bus_out = d; bus_WE = 1'b1;
    @(negedge clk);
    bus_WE = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus_A = a; bus_RE = 1'b1;
    #1;
    d = bus_in;
    bus_RE = 1'b0;
  endtask

  task automatic ld_byte(input logic [9:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #1;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %0b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got %h want 00", tx_data); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %0b want 0", err); else pass_cnt++;
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h002) $display("FAIL rst_status got %h want 00000002", d); else pass_cnt++;
    repeat (3) @(negedge clk);
    bus_rd(32'h408, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL rst_cycles got %h want 0", d); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_rd(32'h408, d);
    total_cnt++; if (d !== 32'h1) $display("FAIL first_incr got %h want 1", d); else pass_cnt++;
  endtask

  task automatic test_load_read;
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < 5; i++) ld_byte(10'(i), 8'(8'h11 * (i + 1)));
    bus_rd(32'h1, d);
    total_cnt++; if (d !== 32'h55443322) $display("FAIL unaligned_rd got %h want 55443322", d); else pass_cnt++;
    bus_rd(32'h0, d);
    total_cnt++; if (d !== 32'h44332211) $display("FAIL aligned_rd got %h want 44332211", d); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    @(negedge clk);
    bus_wr(32'h3FE, 32'hAABBCCDD);
    bus_rd(32'h3FE, d);
    total_cnt++; if (d !== 32'hAABBCCDD) $display("FAIL wrap_rd got %h want AABBCCDD", d); else pass_cnt++;
    bus_rd(32'h3FF, d);
    total_cnt++; if (d !== 32'h33AABBCC) $display("FAIL wrap_3ff got %h want 33AABBCC", d); else pass_cnt++;
    bus_rd(32'h0, d);
    total_cnt++; if (d !== 32'h4433AABB) $display("FAIL wrap_low got %h want 4433AABB", d); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL wrap_err got %0b want 0", err); else pass_cnt++;
  endtask

  task automatic test_ld_collision;
    logic [31:0] d;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'h10; ld_data = 8'h99;
    bus_wr(32'h10, 32'h01020304);
    ld_en = 1'b0;
    bus_rd(32'h10, d);
    total_cnt++; if (d !== 32'h01020304) $display("FAIL ld_clash got %h want 01020304", d); else pass_cnt++;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'h14; ld_data = 8'h77;
    bus_wr(32'h10, 32'h0A0B0C0D);
    ld_en = 1'b0;
    bus_rd(32'h11, d);
    total_cnt++; if (d !== 32'h770A0B0C) $display("FAIL ld_parallel got %h want 770A0B0C", d); else pass_cnt++;
  endtask

  task automatic drain_fifo;
    int guard = 0;
    tx_ready = 1'b1;
    while ((tx_valid || exp_q.size() != 0) && guard < 20) begin
      if (tx_valid) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL tx_extra got %h want none", tx_data);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) $display("FAIL tx_order got %h want %h", tx_data, e); else pass_cnt++;
        end
      end
      @(negedge clk);
      guard++;
    end
    tx_ready = 1'b0;
    total_cnt++; if (guard >= 20) $display("FAIL drain_timeout got %0d left want 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL drain_valid got %0b want 0", tx_valid); else pass_cnt++;
  endtask

  task automatic test_fifo_full;
    logic [31:0] d;
    @(negedge clk);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_wr(32'h404, 32'h41 + i);
      if (i < 4) exp_q.push_back(8'(8'h41 + i));
    end
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h111) $display("FAIL full_status got %h want 00000111", d); else pass_cnt++;
    @(negedge clk);
    drain_fifo();
    bus_wr(32'h400, 32'h100);
    total_cnt++; if (err !== 1'b0) $display("FAIL err_clear got %0b want 0", err); else pass_cnt++;
  endtask

  task automatic test_full_push_pop;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      bus_wr(32'h404, 32'h61 + i);
      exp_q.push_back(8'(8'h61 + i));
    end
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h011) $display("FAIL pp_full got %h want 00000011", d); else pass_cnt++;
    @(negedge clk);
    bus_A = 32'h404; bus_out = 32'h5A; bus_WE = 1'b1; tx_ready = 1'b1;
    #1;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      total_cnt++; if (tx_data !== e) $display("FAIL pp_head got %h want %h", tx_data, e); else pass_cnt++;
    end
    exp_q.push_back(8'h5A);
    @(negedge clk);
    bus_WE = 1'b0; tx_ready = 1'b0;
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h011) $display("FAIL pp_count got %h want 00000011", d); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL pp_err got %0b want 0", err); else pass_cnt++;
    @(negedge clk);
    drain_fifo();
  endtask

  task automatic test_errors;
    logic [31:0] d;
    @(negedge clk);
    bus_A = 32'h0;
    #1;
    total_cnt++; if (bus_in !== 32'h0) $display("FAIL idle_bus got %h want 0", bus_in); else pass_cnt++;
    bus_rd(32'h404, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL rd_txdata got %h want 0", d); else pass_cnt++;
    bus_rd(32'h500, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL rd_unmapped got %h want 0", d); else pass_cnt++;
    @(negedge clk);
    bus_wr(32'h500, 32'h1234);
    total_cnt++; if (err !== 1'b1) $display("FAIL wr_unmapped_err got %0b want 1", err); else pass_cnt++;
    bus_wr(32'h400, 32'h100);
    bus_wr(32'h400, 32'h0);
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h102) $display("FAIL wr_status got %h want 00000102", d); else pass_cnt++;
    @(negedge clk);
    bus_wr(32'h400, 32'h100);
    bus_wr(32'h40, 32'h12345678);
    bus_A = 32'h40; bus_out = 32'hCAFEF00D; bus_RE = 1'b1; bus_WE = 1'b1;
    #1;
    total_cnt++; if (bus_in !== 32'h12345678) $display("FAIL rw_pre got %h want 12345678", bus_in); else pass_cnt++;
    @(negedge clk);
    bus_RE = 1'b0; bus_WE = 1'b0;
    total_cnt++; if (err !== 1'b1) $display("FAIL rw_err got %0b want 1", err); else pass_cnt++;
    bus_rd(32'h40, d);
    total_cnt++; if (d !== 32'hCAFEF00D) $display("FAIL rw_post got %h want CAFEF00D", d); else pass_cnt++;
    // Clear against two simultaneous error sources.
    @(negedge clk);
    bus_A = 32'h400; bus_out = 32'h100; bus_RE = 1'b1; bus_WE = 1'b1;
    @(negedge clk);
    bus_RE = 1'b0; bus_WE = 1'b0;
    total_cnt++; if (err !== 1'b0) $display("FAIL clr_priority got %0b want 0", err); else pass_cnt++;
  endtask

  task automatic test_cycles;
    logic [31:0] d;
    @(negedge clk);
    bus_wr(32'h408, 32'hFFFF);
    repeat (10) @(negedge clk);
    bus_rd(32'h408, d);
    total_cnt++; if (d !== 32'd10) $display("FAIL cyc_10 got %0d want 10", d); else pass_cnt++;
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    @(negedge clk);
    bus_rd(32'h408, d);
    total_cnt++; if (d !== 32'h0) $display("FAIL cyc_wrap got %h want 0", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    @(negedge clk);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_wr(32'h404, 32'h71 + i);
      exp_q.push_back(8'(8'h71 + i));
    end
    bus_wr(32'h500, 32'h0);
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h10C) $display("FAIL pre_rst_status got %h want 0000010C", d); else pass_cnt++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_valid got %0b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", tx_data); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL mid_rst_err got %0b want 0", err); else pass_cnt++;
    bus_rd(32'h400, d);
    total_cnt++; if (d !== 32'h002) $display("FAIL mid_rst_status got %h want 00000002", d); else pass_cnt++;
    bus_rd(32'h10, d);
    total_cnt++; if (d !== 32'h0A0B0C0D) $display("FAIL ram_keep got %h want 0A0B0C0D", d); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL post_rst_valid got %0b want 0", tx_valid); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bus_A = '0; bus_out = '0; bus_RE = 1'b0; bus_WE = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; tx_ready = 1'b0;
    test_reset();
    test_load_read();
    test_wrap();
    test_ld_collision();
    test_fifo_full();
    test_full_push_pop();
    test_errors();
    test_cycles();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
